bsg_nonsynth_dpi_rr_arbiter: RTL
================================

# bsg_nonsynth_dpi_rr_arbiter

Round-robin packet arbiter that shares one downstream DPI host channel among `els_p` requesters in the dpi-verilator platform. It selects one requester, encodes the one-hot grant into a binary tag, and holds the grant for every beat of a multi-beat packet. It also counts completed packets for host-side statistics. The block is simulation-only (non-synthesizable) and is checked by internal one-hot assertions.

## Interface
Parameters:
- `els_p`, 4, number of requesters (>= 1)
- `data_width_p`, 32, bits per beat
- `count_width_p`, 32, width of the completed-packet counter

Ports:
- `clk_i`  in  1  sole clock
- `reset_i`  in  1  synchronous, active-high reset
- `v_i`  in  `els_p`  per-requester beat valid
- `data_i`  in  `els_p*data_width_p`  per-requester beat; requester k occupies bits [k*data_width_p +: data_width_p]
- `last_i`  in  `els_p`  per-requester last-beat-of-packet flag, qualified by `v_i`
- `yumi_o`  out  `els_p`  beat consumed from requester k this cycle; at most one bit set
- `v_o`  out  1  downstream beat valid
- `data_o`  out  `data_width_p`  downstream beat
- `last_o`  out  1  downstream last flag
- `tag_o`  out  `BSG_SAFE_CLOG2(els_p)`  binary index of the granted requester
- `ready_i`  in  1  downstream can accept a beat
- `pkt_count_o`  out  `count_width_p`  completed packets since reset

## Operation
State: `IDLE` (no packet open) and `LOCKED` (owner register holds a requester index). Other registers: round-robin pointer `ptr_r`, `owner_r`, `pkt_count_r`.

- **IDLE, selection.** Form a one-hot grant `g`: the first set bit of `v_i` at or after `ptr_r`, wrapping modulo `els_p`. `g` is zero when `v_i` is zero.
- **IDLE, outputs.** `v_o = |v_i`. `tag_o` = binary encode of `g`. `data_o` and `last_o` come from the granted requester.
- **LOCKED, outputs.**
  - `g` = one-hot of `owner_r`.
  - `v_o = v_i[owner_r]`.
  - Other requesters are ignored, even if valid.
  - `tag_o = owner_r`.
- **Handshake.** A handshake is `v_o & ready_i`. `yumi_o = g` when a handshake occurs, else 0.
- **Handshake with `last_o = 1`.**
  - Next state is `IDLE`.
  - `ptr_r` ← (granted index + 1) mod `els_p`.
  - `pkt_count_r` increments and saturates at all-ones; it does not wrap.
- **Handshake with `last_o = 0` in IDLE.** Next state is `LOCKED`, `owner_r` ← granted index, and `ptr_r` is unchanged.
- **Handshake with `last_o = 0` in LOCKED.** State is held.
- **No handshake.** All state is held. A stalled IDLE selection may change next cycle if `v_i` changes; no grant is latched without a handshake.
- **`els_p = 1`.** `tag_o` is always 0 and the pointer is constant 0. The lock still applies.
- **Reset.** State goes to `IDLE` with `ptr_r = 0`, `owner_r = 0`, `pkt_count_r = 0`. Asserting reset mid-packet drops the lock; the requester restarts arbitration afresh.
- **Assertions** (simulation only, after reset): `$onehot0(yumi_o)`, and `$onehot0(g)`.
- **Outputs during reset:**
  - `yumi_o = 0` and `v_o = 0`.
  - `data_o` and `last_o` are don't-care.
  - `tag_o = 0` and `pkt_count_o = 0`.

## Timing
- Zero-latency combinational path from `v_i`, `data_i` and `last_i` to `v_o`, `data_o`, `last_o` and `tag_o`.
- `yumi_o` depends combinationally on `ready_i`.
- `v_o`, `data_o`, `last_o` and `tag_o` must not depend on `ready_i`, so that a downstream valid→ready loop is impossible.
- State, pointer and counter update only on the `clk_i` rising edge after a handshake.
- `pkt_count_o` reflects a completed packet one cycle after its last-beat handshake.
- Throughput is one beat per cycle, including back-to-back packets from different requesters. There is no idle bubble on a grant switch.
- Fairness: a continuously valid requester is granted within `els_p - 1` packet completions of other requesters.

## Test plan
- **Reset defaults.** Assert reset with all `v_i` = 1 → `yumi_o = 0`, `v_o = 0`, `pkt_count_o = 0`. On the first cycle after reset with `ready_i = 1` → `tag_o = 0`, `yumi_o = 4'b0001`.
- **Rotation.** `els_p = 4`, all requesters valid, single-beat packets (`last_i = 1`), `ready_i = 1` for 8 cycles → `tag_o` sequence is 0,1,2,3,0,1,2,3 and `pkt_count_o` reaches 8.
- **Lock.** Requester 2 sends 3 beats (last on the third) while requesters 0, 1 and 3 are valid → `tag_o = 2` for 3 consecutive handshakes. The next grant is requester 3.
- **Backpressure mid-packet.** Drop `ready_i` for 5 cycles after beat 1 of a 4-beat packet from requester 1, while requester 0 is valid → `yumi_o = 0` throughout, `tag_o` stays 1, and the packet completes with no beat lost or duplicated.
- **Reset mid-packet.** Assert reset during beat 2 of a packet from requester 3 → the lock clears, `ptr_r = 0`, and the next grant goes to the lowest valid index.
- **Counter saturation.** With `count_width_p = 4`, complete 20 packets → `pkt_count_o` holds at 15.

Source files
------------

// File: rtl/bsg_nonsynth_dpi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_nonsynth_dpi_rr_arbiter
// Purpose  : Round-robin packet arbiter sharing one downstream DPI host
//            channel among els_p requesters. The grant is held for every beat
//            of a multi-beat packet, and completed packets are counted with a
//            saturating counter.
// Revision : 1.0  initial release
// ============================================================================
module bsg_nonsynth_dpi_rr_arbiter #(
    parameter int els_p         = 4,
    parameter int data_width_p  = 32,
    parameter int count_width_p = 32,
    localparam int TAG_W        = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [els_p-1:0]              v_i,
    input  logic [els_p*data_width_p-1:0] data_i,
    input  logic [els_p-1:0]              last_i,
    output logic [els_p-1:0]              yumi_o,
    output logic                          v_o,
    output logic [data_width_p-1:0]       data_o,
    output logic                          last_o,
    output logic [TAG_W-1:0]              tag_o,
    input  logic                          ready_i,
    output logic [count_width_p-1:0]      pkt_count_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [TAG_W-1:0]         ptr_q, ptr_d;
    logic [TAG_W-1:0]         owner_q, owner_d;
    logic [count_width_p-1:0] pkt_count_q, pkt_count_d;

    logic [els_p-1:0]         w_rot;
    logic [TAG_W-1:0]         w_off;
    logic [TAG_W:0]           w_sum;
    logic [TAG_W-1:0]         w_sel_idx;
    logic [TAG_W-1:0]         w_gnt_idx;
    logic [TAG_W-1:0]         w_gnt_inc;
    logic [els_p-1:0]         w_g;
    logic                     w_gnt_v;
    logic                     w_gnt_last;
    logic [data_width_p-1:0]  w_gnt_data;
    logic                     w_out_v;
    logic                     w_hs;

    // Round-robin pick: rotate so ptr_q sits at bit 0, take the lowest set
    // bit, then rotate the offset back into an absolute requester index.
    always_comb begin
        w_rot = els_p'({v_i, v_i} >> ptr_q);
        w_off = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = TAG_W'(k);
            end
        end
        w_sum = {1'b0, ptr_q} + {1'b0, w_off};
        if (w_sum >= (TAG_W+1)'(els_p)) begin
            w_sum = w_sum - (TAG_W+1)'(els_p);
        end
        w_sel_idx = w_sum[TAG_W-1:0];
    end

    // Grant mux: the owner wins while locked, otherwise the round-robin pick.
    // Nothing here looks at ready_i, so valid/data/tag never loop back.
    always_comb begin
        w_gnt_idx  = (state_q == ST_LOCKED) ? owner_q : w_sel_idx;
        w_gnt_v    = 1'b0;
        w_gnt_last = 1'b0;
        w_gnt_data = '0;
        w_g        = '0;
        for (int k = 0; k < els_p; k++) begin
            if (w_gnt_idx == TAG_W'(k)) begin
                w_gnt_v    = v_i[k];
                w_gnt_last = last_i[k];
                w_gnt_data = data_i[k*data_width_p +: data_width_p];
                w_g[k]     = (state_q == ST_LOCKED) | (|v_i);
            end
        end
    end

    // Pointer advance target, wrapping at els_p (constant 0 when els_p == 1).
    assign w_gnt_inc = (w_gnt_idx == TAG_W'(els_p - 1)) ? '0 : w_gnt_idx + TAG_W'(1);

    assign w_out_v = ~reset_i & w_gnt_v;
    assign w_hs    = w_out_v & ready_i;

    // State register: packet lock, pointer, owner and completed-packet count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Next state: lock on a non-final beat, release and rotate on a last beat.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        pkt_count_d = pkt_count_q;
        if (w_hs) begin
            if (w_gnt_last) begin
                state_d = ST_IDLE;
                ptr_d   = w_gnt_inc;
                if (~&pkt_count_q) begin
                    pkt_count_d = pkt_count_q + count_width_p'(1);
                end
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCKED;
                owner_d = w_gnt_idx;
            end
        end
    end

    // Outputs: quiet during reset so a half-reset state never leaks out.
    always_comb begin
        v_o         = w_out_v;
        data_o      = w_gnt_data;
        last_o      = w_gnt_last;
        tag_o       = reset_i ? '0 : w_gnt_idx;
        yumi_o      = w_hs ? w_g : '0;
        pkt_count_o = reset_i ? '0 : pkt_count_q;
    end

    // Grant sanity: at most one requester consumed or granted per cycle.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(yumi_o));
            assert ($onehot0(w_g));
        end
    end

endmodule
`default_nettype wire
